uart_crc_frame_checker: RTL and testbench

//  Downstream consumer of the UART receiver. Assembles received bytes into length-prefixed frames:
//  [LEN][PAYLOAD x LEN][CRC8]. Streams payload bytes onward and computes CRC-8 over the payload.

---
 rtl/uart_crc_frame_checker_pkg.sv | 28 ++
 rtl/uart_crc_frame_checker_if.sv | 27 ++
 rtl/uart_crc_frame_checker_crc8.sv | 14 +
 rtl/uart_crc_frame_checker.sv | 112 +++++++++++
 tb/tb_uart_crc_frame_checker.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_crc_frame_checker_pkg.sv
// Shared types, defaults and the CRC-8 step function for the UART frame checker
// and the future transmit-side CRC generator.
package uart_crc_pkg;

    localparam int N = 8;

    localparam logic [N-1:0] CRC_POLY = 8'h07;
    localparam logic [N-1:0] CRC_INIT = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CRC     = 2'd2
    } state_t;

    // MSB-first, non-reflected, no final XOR; all 8 shifts happen in one cycle.
    function automatic logic [N-1:0] crc8_update(input logic [N-1:0] crc,
                                                  input logic [N-1:0] data,
                                                  input logic [N-1:0] poly);
        logic [N-1:0] c;
        c = crc ^ data;
        for (int i = 0; i < N; i++) begin
            c = c[N-1] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_crc_frame_checker_if.sv
// Byte stream in from the UART receiver, payload stream and frame verdicts out.
interface uart_crc_frame_checker_if;
    import uart_crc_pkg::*;

    logic [N-1:0] byte_i;
    logic         byte_valid_i;
    logic [N-1:0] payload_o;
    logic         payload_valid_o;
    logic         frame_done_o;
    logic         crc_ok_o;
    logic         len_err_o;
    logic         timeout_o;
    logic         busy_o;

    modport master (
        output byte_i, byte_valid_i,
        input  payload_o, payload_valid_o, frame_done_o, crc_ok_o,
               len_err_o, timeout_o, busy_o
    );

    modport slave (
        input  byte_i, byte_valid_i,
        output payload_o, payload_valid_o, frame_done_o, crc_ok_o,
               len_err_o, timeout_o, busy_o
    );

endinterface

// File: rtl/uart_crc_frame_checker_crc8.sv
// One-byte CRC-8 step; combinational so a whole byte is absorbed per clock.
module crc8_byte_update
    import uart_crc_pkg::*;
#(
    parameter logic [N-1:0] POLY = CRC_POLY
) (
    input  logic [N-1:0] crc_i,
    input  logic [N-1:0] data_i,
    output logic [N-1:0] crc_o
);

    assign crc_o = crc8_update(crc_i, data_i, POLY);

endmodule

// File: rtl/uart_crc_frame_checker.sv
// Assembles [LEN][PAYLOAD x LEN][CRC8] frames from received bytes, forwards the
// payload and reports a CRC verdict, a bad length or an inter-byte timeout.
module uart_crc_frame_checker
    import uart_crc_pkg::*;
#(
    parameter int           MAX_LEN     = 64,
    parameter logic [N-1:0] POLY        = CRC_POLY,
    parameter logic [N-1:0] INIT        = CRC_INIT,
    parameter int           TIMEOUT_CYC = 16384
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    uart_crc_frame_checker_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    state_t             state;
    logic [CNT_W-1:0]   remaining;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [N-1:0]       crc_q;
    logic [N-1:0]       crc_next;
    logic [N-1:0]       payload_q;
    logic               payload_valid_q;
    logic               frame_done_q;
    logic               crc_ok_q;
    logic               len_err_q;
    logic               timeout_q;
    logic               len_ok;

    crc8_byte_update #(.POLY(POLY)) u_crc (
        .crc_i  (crc_q),
        .data_i (bus.byte_i),
        .crc_o  (crc_next)
    );

    assign len_ok = (bus.byte_i != '0) && (bus.byte_i <= N'(MAX_LEN));

    // An arriving byte always takes priority over timeout expiry in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state           <= IDLE;
            remaining       <= '0;
            tmo_cnt         <= '0;
            crc_q           <= INIT;
            payload_q       <= '0;
            payload_valid_q <= 1'b0;
            frame_done_q    <= 1'b0;
            crc_ok_q        <= 1'b0;
            len_err_q       <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            payload_valid_q <= 1'b0;
            frame_done_q    <= 1'b0;
            crc_ok_q        <= 1'b0;
            len_err_q       <= 1'b0;
            timeout_q       <= 1'b0;

            if (bus.byte_valid_i) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (len_ok) begin
                            remaining <= CNT_W'(bus.byte_i);
                            crc_q     <= INIT;
                            state     <= PAYLOAD;
                        end else begin
                            len_err_q <= 1'b1;
                        end
                    end
                    PAYLOAD: begin
                        payload_q       <= bus.byte_i;
                        payload_valid_q <= 1'b1;
                        crc_q           <= crc_next;
                        remaining       <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= CRC;
                        end
                    end
                    CRC: begin
                        frame_done_q <= 1'b1;
                        crc_ok_q     <= (bus.byte_i == crc_q);
                        state        <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                    timeout_q <= 1'b1;
                    state     <= IDLE;
                    crc_q     <= INIT;
                    remaining <= '0;
                    tmo_cnt   <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    assign bus.payload_o       = payload_q;
    assign bus.payload_valid_o = payload_valid_q;
    assign bus.frame_done_o    = frame_done_q;
    assign bus.crc_ok_o        = crc_ok_q;
    assign bus.len_err_o       = len_err_q;
    assign bus.timeout_o       = timeout_q;
    assign bus.busy_o          = (state == PAYLOAD) || (state == CRC);

endmodule

// File: tb/tb_uart_crc_frame_checker.sv
// Directed scenarios for the UART CRC frame checker with hand-computed CRC values.
module tb_uart_crc_frame_checker;

    localparam int T = 16384;

    logic clk = 1'b0;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    int n_done  = 0;
    int n_ok    = 0;
    int n_len   = 0;
    int n_tmo   = 0;
    int n_busy  = 0;
    int n_stray = 0;
    logic [7:0] pay_q[$];

    always #5 clk = ~clk;

    uart_crc_frame_checker_if ifc ();

    uart_crc_frame_checker #(
        .MAX_LEN     (64),
        .POLY        (8'h07),
        .INIT        (8'h00),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifc)
    );

    // Event recorder; outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (ifc.payload_valid_o === 1'b1) pay_q.push_back(ifc.payload_o);
        if (ifc.frame_done_o === 1'b1) begin
            n_done++;
            if (ifc.crc_ok_o === 1'b1) n_ok++;
        end
        if (ifc.crc_ok_o === 1'b1 && ifc.frame_done_o !== 1'b1) n_stray++;
        if (ifc.len_err_o === 1'b1) n_len++;
        if (ifc.timeout_o === 1'b1) n_tmo++;
        if (ifc.busy_o === 1'b1) n_busy++;
    end

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        ifc.byte_i       = b;
        ifc.byte_valid_i = 1'b1;
        @(negedge clk);
        ifc.byte_valid_i = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        ifc.byte_i       = 8'h00;
        ifc.byte_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({ifc.payload_o, ifc.payload_valid_o, ifc.frame_done_o, ifc.crc_ok_o,
             ifc.len_err_o, ifc.timeout_o, ifc.busy_o} !== 15'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got payload=%h pv=%b done=%b ok=%b len=%b tmo=%b busy=%b, want all 0",
                     ifc.payload_o, ifc.payload_valid_o, ifc.frame_done_o, ifc.crc_ok_o,
                     ifc.len_err_o, ifc.timeout_o, ifc.busy_o);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_digits_frame(input logic [7:0] crc_byte, input int want_ok, input string tag);
        int q0 = pay_q.size();
        int d0 = n_done;
        int o0 = n_ok;
        int s0 = n_stray;
        send(8'h09, 9);
        for (int i = 0; i < 9; i++) send(8'h31 + 8'(i), 9);
        send(crc_byte, 9);
        total++;
        if (pay_q.size() - q0 != 9) begin
            bad++;
            $display("[TB] FAIL %s_payload_count: got %0d, want 9", tag, pay_q.size() - q0);
        end
        for (int i = 0; i < 9; i++) begin
            if (q0 + i < pay_q.size()) begin
                total++;
                if (pay_q[q0 + i] !== 8'h31 + 8'(i)) begin
                    bad++;
                    $display("[TB] FAIL %s_payload[%0d]: got %h, want %h", tag, i, pay_q[q0 + i], 8'h31 + 8'(i));
                end
            end
        end
        total++;
        if (n_done - d0 != 1) begin
            bad++;
            $display("[TB] FAIL %s_frame_done: got %0d strobes, want 1", tag, n_done - d0);
        end
        total++;
        if (n_ok - o0 != want_ok) begin
            bad++;
            $display("[TB] FAIL %s_crc_ok: got %0d, want %0d", tag, n_ok - o0, want_ok);
        end
        total++;
        if (n_stray != s0) begin
            bad++;
            $display("[TB] FAIL %s_crc_ok_without_done: got %0d, want 0", tag, n_stray - s0);
        end
    endtask

    task automatic test_good_frame();
        run_digits_frame(8'hF4, 1, "good");
    endtask

    task automatic test_bad_crc();
        run_digits_frame(8'hF5, 0, "badcrc");
    endtask

    task automatic test_len_err();
        int q0 = pay_q.size();
        int l0 = n_len;
        int b0 = n_busy;
        send(8'h00, 3);
        send(8'h41, 3);
        total++;
        if (n_len - l0 != 2) begin
            bad++;
            $display("[TB] FAIL len_err_count: got %0d, want 2", n_len - l0);
        end
        total++;
        if (pay_q.size() != q0) begin
            bad++;
            $display("[TB] FAIL len_err_payload: got %0d strobes, want 0", pay_q.size() - q0);
        end
        total++;
        if (n_busy != b0) begin
            bad++;
            $display("[TB] FAIL len_err_busy: got %0d busy cycles, want 0", n_busy - b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [6] = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h00, 8'h00};
        int q0 = pay_q.size();
        int d0 = n_done;
        int o0 = n_ok;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ifc.byte_i       = seq[i];
            ifc.byte_valid_i = 1'b1;
        end
        @(negedge clk);
        ifc.byte_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (n_done - d0 != 2 || n_ok - o0 != 2) begin
            bad++;
            $display("[TB] FAIL b2b_verdicts: got done=%0d ok=%0d, want done=2 ok=2", n_done - d0, n_ok - o0);
        end
        total++;
        if (pay_q.size() - q0 != 2) begin
            bad++;
            $display("[TB] FAIL b2b_payload_count: got %0d, want 2", pay_q.size() - q0);
        end else begin
            total++;
            if (pay_q[q0] !== 8'h01 || pay_q[q0 + 1] !== 8'h00) begin
                bad++;
                $display("[TB] FAIL b2b_payload_values: got %h %h, want 01 00", pay_q[q0], pay_q[q0 + 1]);
            end
        end
    endtask

    task automatic test_timeout();
        int d0;
        int o0;
        int t0;
        send(8'h03, 2);
        send(8'hAA, 2);
        @(negedge clk);
        ifc.byte_i       = 8'hBB;
        ifc.byte_valid_i = 1'b1;
        @(negedge clk);
        ifc.byte_valid_i = 1'b0;
        repeat (T - 1) @(negedge clk);
        total++;
        if (ifc.timeout_o !== 1'b0 || ifc.busy_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL timeout_early: got tmo=%b busy=%b, want tmo=0 busy=1", ifc.timeout_o, ifc.busy_o);
        end
        @(negedge clk);
        total++;
        if (ifc.timeout_o !== 1'b1 || ifc.busy_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_fire: got tmo=%b busy=%b, want tmo=1 busy=0", ifc.timeout_o, ifc.busy_o);
        end
        @(negedge clk);
        total++;
        if (ifc.timeout_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_width: got tmo=%b one cycle later, want 0", ifc.timeout_o);
        end

        d0 = n_done;
        o0 = n_ok;
        send(8'h01, 2);
        send(8'h01, 2);
        send(8'h07, 3);
        total++;
        if (n_done - d0 != 1 || n_ok - o0 != 1) begin
            bad++;
            $display("[TB] FAIL after_timeout_frame: got done=%0d ok=%0d, want 1 1", n_done - d0, n_ok - o0);
        end

        t0 = n_tmo;
        d0 = n_done;
        o0 = n_ok;
        send(8'h02, 2);
        @(negedge clk);
        ifc.byte_i       = 8'h00;
        ifc.byte_valid_i = 1'b1;
        @(negedge clk);
        ifc.byte_valid_i = 1'b0;
        repeat (T - 1) @(negedge clk);
        ifc.byte_i       = 8'h01;
        ifc.byte_valid_i = 1'b1;
        @(negedge clk);
        ifc.byte_valid_i = 1'b0;
        total++;
        if (ifc.timeout_o !== 1'b0 || ifc.payload_valid_o !== 1'b1 ||
            ifc.payload_o !== 8'h01 || ifc.busy_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL expiry_byte_wins: got tmo=%b pv=%b payload=%h busy=%b, want 0 1 01 1",
                     ifc.timeout_o, ifc.payload_valid_o, ifc.payload_o, ifc.busy_o);
        end
        send(8'h07, 3);
        total++;
        if (n_tmo != t0 || n_done - d0 != 1 || n_ok - o0 != 1) begin
            bad++;
            $display("[TB] FAIL expiry_frame: got tmo=%0d done=%0d ok=%0d, want 0 1 1",
                     n_tmo - t0, n_done - d0, n_ok - o0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int q0;
        int d0;
        int o0;
        send(8'h02, 2);
        send(8'h31, 2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({ifc.payload_o, ifc.payload_valid_o, ifc.frame_done_o, ifc.crc_ok_o,
             ifc.len_err_o, ifc.timeout_o, ifc.busy_o} !== 15'h0) begin
            bad++;
            $display("[TB] FAIL midreset_outputs: got payload=%h pv=%b done=%b ok=%b len=%b tmo=%b busy=%b, want all 0",
                     ifc.payload_o, ifc.payload_valid_o, ifc.frame_done_o, ifc.crc_ok_o,
                     ifc.len_err_o, ifc.timeout_o, ifc.busy_o);
        end
        q0 = pay_q.size();
        d0 = n_done;
        o0 = n_ok;
        send(8'h01, 2);
        send(8'h01, 2);
        send(8'h07, 3);
        total++;
        if (n_done - d0 != 1 || n_ok - o0 != 1 || pay_q.size() - q0 != 1) begin
            bad++;
            $display("[TB] FAIL midreset_next_frame: got done=%0d ok=%0d payloads=%0d, want 1 1 1",
                     n_done - d0, n_ok - o0, pay_q.size() - q0);
        end else begin
            total++;
            if (pay_q[q0] !== 8'h01) begin
                bad++;
                $display("[TB] FAIL midreset_payload: got %h, want 01", pay_q[q0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_len_err();
        test_back_to_back();
        test_timeout();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
